// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage. It accepts one load/store request,
// waits WAIT_STATES cycles, then performs the access and raises memReady for
// exactly one cycle. Rejected requests raise memError, clear memReadData and
// leave the array untouched.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  ST_IDLE | waiting for memRead/memWrite; request fields latched on accept
//  ST_WAIT | wait counter running down to zero
//  ST_RESP | access done; memReady (and memError if rejected) high this cycle
module data_mem_responder #(
    parameter int WORD_BITWIDTH   = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_STATES     = 1
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     memRead,
    input  logic                     memWrite,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] address,
    input  logic [WORD_BITWIDTH-1:0] memWriteData,
    output logic [WORD_BITWIDTH-1:0] memReadData,
    output logic                     memReady,
    output logic                     memError
);

    localparam int W     = WORD_BITWIDTH;
    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [W-1:0]   addr_q;
    logic [W-1:0]   wdata_q;
    logic [2:0]     f3_q;
    logic           rd_q;
    logic           wr_q;
    logic [W-1:0]   rdata_q;
    logic           ready_q;
    logic           err_q;

    logic [W-1:0]   mem_q [MEM_DEPTH_WORDS];

    // With zero wait states the response is formed straight from the inputs on
    // the accept edge, so the access logic looks at the live request in IDLE.
    logic [W-1:0]   sel_addr;
    logic [W-1:0]   sel_wdata;
    logic [2:0]     sel_f3;
    logic           sel_rd;
    logic           sel_wr;
    logic           go_resp;
    logic [W-3:0]   word_idx;
    logic [IDX_W-1:0] idx;
    logic [1:0]     lane;
    logic [W-1:0]   cur_word;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [W-1:0]   load_val;
    logic [W-1:0]   wr_word_d;
    logic [W-1:0]   rdata_d;
    logic           req_err;
    logic           mem_we;

    // Request decode, error classification, load extraction and store merge.
    always_comb begin
        sel_addr  = (state_q == ST_IDLE) ? address      : addr_q;
        sel_wdata = (state_q == ST_IDLE) ? memWriteData : wdata_q;
        sel_f3    = (state_q == ST_IDLE) ? funct3       : f3_q;
        sel_rd    = (state_q == ST_IDLE) ? memRead      : rd_q;
        sel_wr    = (state_q == ST_IDLE) ? memWrite     : wr_q;

        go_resp = ((state_q == ST_IDLE) && (memRead || memWrite) && (WAIT_STATES == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd0));

        word_idx = sel_addr[W-1:2];
        idx      = word_idx[IDX_W-1:0];
        lane     = sel_addr[1:0];
        cur_word = mem_q[idx];
        byte_v   = cur_word[{lane, 3'b000} +: 8];
        half_v   = cur_word[{sel_addr[1], 4'b0000} +: 16];

        req_err = 1'b0;
        if (sel_rd && sel_wr)                                      req_err = 1'b1;
        if (sel_f3 == 3'd3 || sel_f3 == 3'd6 || sel_f3 == 3'd7)    req_err = 1'b1;
        if ((sel_f3 == 3'd4 || sel_f3 == 3'd5) && sel_wr)          req_err = 1'b1;
        if ((sel_f3 == 3'd1 || sel_f3 == 3'd5) && sel_addr[0])     req_err = 1'b1;
        if ((sel_f3 == 3'd2) && (sel_addr[1:0] != 2'b00))          req_err = 1'b1;
        if (word_idx >= (W-2)'(MEM_DEPTH_WORDS))                   req_err = 1'b1;

        case (sel_f3)
            3'd0:    load_val = {{(W-8){byte_v[7]}}, byte_v};
            3'd1:    load_val = {{(W-16){half_v[15]}}, half_v};
            3'd4:    load_val = {{(W-8){1'b0}}, byte_v};
            3'd5:    load_val = {{(W-16){1'b0}}, half_v};
            default: load_val = cur_word;
        endcase

        wr_word_d = cur_word;
        case (sel_f3)
            3'd0:    wr_word_d[{lane, 3'b000} +: 8]          = sel_wdata[7:0];
            3'd1:    wr_word_d[{sel_addr[1], 4'b0000} +: 16] = sel_wdata[15:0];
            default: wr_word_d                               = sel_wdata;
        endcase

        if (req_err)     rdata_d = '0;
        else if (sel_rd) rdata_d = load_val;
        else             rdata_d = rdata_q;

        mem_we = go_resp && sel_wr && !req_err && rstN;
    end

    // Word array; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wr_word_d;
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (memRead || memWrite) begin
                        addr_q  <= address;
                        wdata_q <= memWriteData;
                        f3_q    <= funct3;
                        rd_q    <= memRead;
                        wr_q    <= memWrite;
                        if (go_resp) begin
                            state_q <= ST_RESP;
                            ready_q <= 1'b1;
                            err_q   <= req_err;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (go_resp) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                        err_q   <= req_err;
                        rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign memReadData = rdata_q;
    assign memReady    = ready_q;
    assign memError    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with one wait state, one with none.
module tb_data_mem_responder;

    logic        clk;
    logic        rstN;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [2:0]  a_f3, b_f3;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ready, a_err, b_ready, b_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];

    data_mem_responder #(.WORD_BITWIDTH(32), .MEM_DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
        .clk(clk), .rstN(rstN), .memRead(a_rd), .memWrite(a_wr), .funct3(a_f3),
        .address(a_addr), .memWriteData(a_wdata), .memReadData(a_rdata),
        .memReady(a_ready), .memError(a_err)
    );

    data_mem_responder #(.WORD_BITWIDTH(32), .MEM_DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rstN(rstN), .memRead(b_rd), .memWrite(b_wr), .funct3(b_f3),
        .address(b_addr), .memWriteData(b_wdata), .memReadData(b_rdata),
        .memReady(b_ready), .memError(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge. Pushes the expectation, drives the request, waits for
    // memReady, then pops and compares. hold keeps the request on the pins.
    task automatic do_req(input bit use_b, input string name, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int lat,
                          input bit hold);
        exp_t e;
        int   n;
        logic rdy;
        sb_q.push_back({exp_data, exp_err, 8'(lat)});
        if (use_b) begin
            b_rd = rd; b_wr = wr; b_f3 = f3; b_addr = addr; b_wdata = wdata;
        end else begin
            a_rd = rd; a_wr = wr; a_f3 = f3; a_addr = addr; a_wdata = wdata;
        end
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
            rdy = use_b ? b_ready : a_ready;
            if (!rdy) begin
                n_checks++;
                if ((use_b ? b_err : a_err) !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s err_outside_resp: got 1 required 0", name);
                end
            end
        end
        e = sb_q.pop_front();
        n_checks++;
        if (!rdy) begin
            n_errors++;
            $display("FAIL %s timeout: no memReady within %0d cycles", name, n);
        end else begin
            if (n !== int'(e.lat)) begin
                n_errors++;
                $display("FAIL %s latency: got %0d required %0d", name, n, e.lat);
            end
            n_checks++;
            if ((use_b ? b_rdata : a_rdata) !== e.data) begin
                n_errors++;
                $display("FAIL %s data: got %h required %h", name, use_b ? b_rdata : a_rdata, e.data);
            end
            n_checks++;
            if ((use_b ? b_err : a_err) !== e.err) begin
                n_errors++;
                $display("FAIL %s memError: got %b required %b", name, use_b ? b_err : a_err, e.err);
            end
        end
        if (!hold) begin
            if (use_b) begin b_rd = 0; b_wr = 0; end
            else       begin a_rd = 0; a_wr = 0; end
            @(negedge clk);
            n_checks++;
            if ((use_b ? b_ready : a_ready) !== 1'b0) begin
                n_errors++;
                $display("FAIL %s ready_pulse: got 1 required 0 one cycle later", name);
            end
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        a_rd = 0; a_wr = 0; a_f3 = 0; a_addr = 0; a_wdata = 0;
        b_rd = 0; b_wr = 0; b_f3 = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_rdata, a_ready, a_err} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_state: got rdata=%h ready=%b err=%b required all 0", a_rdata, a_ready, a_err);
        end
    endtask

    task automatic test_store_load();
        do_req(0, "sw_10",  0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0);
        do_req(0, "lw_10",  1, 0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0);
        do_req(0, "lb_13",  1, 0, 3'd0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, 0);
        do_req(0, "lbu_13", 1, 0, 3'd4, 32'h13, 32'h0,        32'h000000DE, 0, 2, 0);
        do_req(0, "lh_12",  1, 0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 0);
        do_req(0, "lhu_10", 1, 0, 3'd5, 32'h10, 32'h0,        32'h0000BEEF, 0, 2, 0);
    endtask

    task automatic test_byte_store();
        do_req(0, "sb_11",     0, 1, 3'd0, 32'h11, 32'h12345678, 32'h0000BEEF, 0, 2, 0);
        do_req(0, "lw_after_sb", 1, 0, 3'd2, 32'h10, 32'h0,      32'hDEAD78EF, 0, 2, 0);
    endtask

    task automatic test_errors();
        do_req(0, "lh_misalign",  1, 0, 3'd1, 32'h11,   32'h0,        32'h0, 1, 2, 0);
        do_req(0, "sw_misalign",  0, 1, 3'd2, 32'h12,   32'h55555555, 32'h0, 1, 2, 0);
        do_req(0, "lw_range",     1, 0, 3'd2, 32'h1000, 32'h0,        32'h0, 1, 2, 0);
        do_req(0, "lw_after_err", 1, 0, 3'd2, 32'h10,   32'h0,        32'hDEAD78EF, 0, 2, 0);
        do_req(0, "rd_and_wr",    1, 1, 3'd2, 32'h10,   32'h0,        32'h0, 1, 2, 0);
        do_req(0, "funct3_3",     1, 0, 3'd3, 32'h10,   32'h0,        32'h0, 1, 2, 0);
        do_req(0, "sbu_store",    0, 1, 3'd4, 32'h10,   32'h0,        32'h0, 1, 2, 0);
        do_req(0, "funct3_6",     1, 0, 3'd6, 32'h10,   32'h0,        32'h0, 1, 2, 0);
        do_req(0, "lw_no_change", 1, 0, 3'd2, 32'h10,   32'h0,        32'hDEAD78EF, 0, 2, 0);
    endtask

    task automatic test_boundary();
        do_req(0, "sw_last",  0, 1, 3'd2, 32'hFFC, 32'h0BADF00D, 32'hDEAD78EF, 0, 2, 0);
        do_req(0, "lw_last",  1, 0, 3'd2, 32'hFFC, 32'h0,        32'h0BADF00D, 0, 2, 0);
        do_req(0, "lw_10_ok", 1, 0, 3'd2, 32'h10,  32'h0,        32'hDEAD78EF, 0, 2, 0);
    endtask

    task automatic test_back_to_back();
        do_req(0, "b2b_first",  1, 0, 3'd2, 32'hFFC, 32'h0, 32'h0BADF00D, 0, 2, 1);
        do_req(0, "b2b_second", 1, 0, 3'd5, 32'h12,  32'h0, 32'h0000DEAD, 0, 3, 1);
        do_req(0, "b2b_repeat", 1, 0, 3'd5, 32'h12,  32'h0, 32'h0000DEAD, 0, 3, 0);
    endtask

    task automatic test_zero_wait();
        do_req(1, "zw_sw", 0, 1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0,        0, 1, 0);
        do_req(1, "zw_lw", 1, 0, 3'd2, 32'h20, 32'h0,        32'hCAFEF00D, 0, 1, 0);
        do_req(1, "zw_lb", 1, 0, 3'd0, 32'h21, 32'h0,        32'hFFFFFFF0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        do_req(0, "lw_pre_rst", 1, 0, 3'd2, 32'h10, 32'h0, 32'hDEAD78EF, 0, 2, 0);
        a_rd = 0; a_wr = 1; a_f3 = 3'd2; a_addr = 32'h10; a_wdata = 32'h0;
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        n_checks++;
        if ({a_rdata, a_ready, a_err} !== 34'd0) begin
            n_errors++;
            $display("FAIL async_reset_a: got rdata=%h ready=%b err=%b required all 0", a_rdata, a_ready, a_err);
        end
        n_checks++;
        if (b_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset_b: got rdata=%h required 0", b_rdata);
        end
        a_wr = 0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        do_req(0, "lw_post_rst", 1, 0, 3'd2, 32'h10, 32'h0, 32'hDEAD78EF, 0, 2, 0);
        do_req(1, "zw_post_rst", 1, 0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_store();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_zero_wait();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
